// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IR word layout, opcode constants and the fetch-stage state encoding.
package cpu_pkg;

   localparam int IR_W = 32;

   localparam int OPER_MSB     = 31;
   localparam int OPER_LSB     = 27;
   localparam int RDST_MSB     = 26;
   localparam int RDST_LSB     = 22;
   localparam int RSRC1_MSB    = 21;
   localparam int RSRC1_LSB    = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RSRC2_MSB    = 15;
   localparam int RSRC2_LSB    = 0;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;
   localparam logic [4:0] OP_ROR     = 5'd5;
   localparam logic [4:0] OP_RAND    = 5'd6;
   localparam logic [4:0] OP_RXOR    = 5'd7;
   localparam logic [4:0] OP_RXNOR   = 5'd8;
   localparam logic [4:0] OP_RNAND   = 5'd9;
   localparam logic [4:0] OP_RNOR    = 5'd10;
   localparam logic [4:0] OP_RNOT    = 5'd11;
   localparam logic [4:0] OP_HALT    = 5'b11111;

   typedef enum logic {
      FS_IDLE  = 1'b0,
      FS_FETCH = 1'b1
   } fetch_state_e;

   function automatic logic [4:0] ir_oper(input logic [IR_W-1:0] ir);
      return ir[OPER_MSB:OPER_LSB];
   endfunction

   function automatic logic is_halt(input logic [IR_W-1:0] ir);
      return ir_oper(ir) == OP_HALT;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage buses: read port to instruction memory and the IR handshake towards execute.
interface instr_fetch_if #(
   parameter int ADDR_W = 5
);
   import cpu_pkg::*;

   logic              imem_rd_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [IR_W-1:0]   imem_rdata;

   logic              ir_valid;
   logic              ir_ready;
   logic [IR_W-1:0]   ir_data;
   logic [ADDR_W-1:0] ir_pc;

   modport master (
      output imem_rd_en, imem_addr,
      input  imem_rdata,
      output ir_valid, ir_data, ir_pc,
      input  ir_ready
   );

   modport slave (
      input  imem_rd_en, imem_addr,
      output imem_rdata,
      input  ir_valid, ir_data, ir_pc,
      output ir_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding fetched words with their addresses; head is shown combinationally.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              push,
   input  logic [IR_W-1:0]   push_data,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic              pop,
   input  logic              flush,
   output logic [IR_W-1:0]   head_data,
   output logic [ADDR_W-1:0] head_pc,
   output logic [1:0]        occupancy
);

   logic [IR_W-1:0]   data_q [2];
   logic [IR_W-1:0]   data_d [2];
   logic [ADDR_W-1:0] pc_q   [2];
   logic [ADDR_W-1:0] pc_d   [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   // NOTE: every output of this block gets a default first so no path leaves a value unassigned and infers a latch.
   always_comb begin
      data_d   = data_q;
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            data_d[wr_ptr_q] = push_data;
            pc_d[wr_ptr_q]   = push_pc;
            wr_ptr_d         = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         // NOTE: the two storage entries are reset because the head drives ir_data/ir_pc, which must read zero out of reset.
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= data_d[i];
            pc_q[i]   <= pc_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = data_q[rd_ptr_q];
   assign head_pc   = pc_q[rd_ptr_q];
   assign occupancy = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/FETCH control, PC, one-cycle memory read pipeline and 2-entry IR buffer.
// Optional macro FETCH_HALT_DECODE_EN stops fetching after a captured HALT word.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              start,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              busy,
   instr_fetch_if.master     bus
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;

   logic [1:0]        occ;
   logic [IR_W-1:0]   head_data;
   logic [ADDR_W-1:0] head_pc;
   logic              ir_valid;
   logic              pop;
   logic              push;
   logic              halt_cap;
   logic              issue;
   logic [2:0]        demand;

   assign ir_valid = (occ != 2'd0);

   always_comb begin
      pop  = ir_valid && bus.ir_ready;
      push = pend_q && !redirect_valid;
`ifdef FETCH_HALT_DECODE_EN
      halt_cap = push && is_halt(bus.imem_rdata);
`else
      halt_cap = 1'b0;
`endif
      // Entries that will be held once everything already requested lands; a new read must leave room.
      demand = 3'(occ) + 3'(pend_q) - 3'(pop);
      issue  = (state_q == FS_FETCH) && !sys_rst && !halt && !redirect_valid
               && !halt_cap && (demand < 3'd2);

      state_d = state_q;
      case (state_q)
         FS_IDLE:  if (start) state_d = FS_FETCH;
         FS_FETCH: if (halt || halt_cap) state_d = FS_IDLE;
         default:  state_d = FS_IDLE;
      endcase

      pc_d = pc_q;
      if (issue) pc_d = pc_q + ADDR_W'(1);
      if (halt_cap) pc_d = resp_pc_q + ADDR_W'(1);
      if (redirect_valid) pc_d = redirect_pc;

      pend_d    = issue;
      resp_pc_d = issue ? pc_q : resp_pc_q;
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q   <= FS_IDLE;
         pc_q      <= '0;
         pend_q    <= 1'b0;
         resp_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         resp_pc_q <= resp_pc_d;
      end
   end

   fetch_fifo #(
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .sys_rst   (sys_rst),
      .push      (push),
      .push_data (bus.imem_rdata),
      .push_pc   (resp_pc_q),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (head_data),
      .head_pc   (head_pc),
      .occupancy (occ)
   );

   assign bus.imem_rd_en = issue;
   assign bus.imem_addr  = pc_q;
   assign bus.ir_valid   = ir_valid;
   assign bus.ir_data    = head_data;
   assign bus.ir_pc      = head_pc;
   assign busy           = (state_q == FS_FETCH) || pend_q || ir_valid;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 5, giving the instruction memory address width (2^ADDR_W words).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The module SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1, a pulse that moves IDLE to FETCH.
REQ-005 The module SHALL have port halt, input, 1, a pulse that stops issuing reads (FETCH to IDLE).
REQ-006 The module SHALL have ports redirect_valid, input, 1, and redirect_pc, input, ADDR_W, which together load a new PC and flush.
REQ-007 The module SHALL have ports imem_rd_en, output, 1, and imem_addr, output, ADDR_W, forming the read request to instruction memory.
REQ-008 The module SHALL have port imem_rdata, input, 32, the read data, valid exactly 1 cycle after imem_rd_en.
REQ-009 The module SHALL have ports ir_valid, output, 1, ir_ready, input, 1, ir_data, output, 32, and ir_pc, output, ADDR_W, forming the instruction handshake to the execute stage; ir_data carries the 32-bit IR word (oper[31:27], rdst[26:22], rsrc1[21:17], imm_mode[16], rsrc2/isrc[15:0]).
REQ-010 The module SHALL have port busy, output, 1, high when in FETCH, a read is in flight, or the buffer is non-empty.

Function
REQ-011 The module SHALL have states IDLE and FETCH.
REQ-012 In IDLE, start SHALL cause FETCH on the next cycle; halt in FETCH SHALL cause IDLE on the next cycle; halt in IDLE and start in FETCH SHALL be ignored.
REQ-013 In FETCH, imem_rd_en SHALL be asserted with imem_addr=PC whenever (occupancy + inflight - pop_this_cycle) < 2; PC SHALL increment on each issued read.
REQ-014 PC SHALL wrap from 2^ADDR_W-1 to 0.
REQ-015 A returning read SHALL be written into a 2-entry FIFO at the end of the response cycle, together with its address; the earliest ir_valid is 2 cycles after imem_rd_en.
REQ-016 ir_data and ir_pc SHALL present the FIFO head; a transfer occurs when ir_valid && ir_ready; ir_valid/ir_data SHALL remain stable while ir_ready is low.
REQ-017 With ir_ready held high, sustained throughput SHALL be 1 instruction per cycle; the FIFO SHALL never overflow.
REQ-018 On redirect_valid, in any state, the module SHALL flush the FIFO, discard any in-flight response, load PC=redirect_pc, and drive ir_valid low in the next cycle; a read of redirect_pc SHALL issue in the next cycle if in FETCH.
REQ-019 Simultaneous redirect_valid and halt SHALL apply the flush and PC load and enter IDLE; simultaneous redirect_valid and start in IDLE SHALL load PC and enter FETCH.
REQ-020 After halt, an in-flight response SHALL still be captured and the buffered entries SHALL drain normally.
REQ-021 A pop and a push in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-022 sys_rst SHALL set state=IDLE, PC=0, FIFO empty, inflight=0, ir_valid=0, imem_rd_en=0, imem_addr=0, ir_data=0, ir_pc=0, and busy=0.
REQ-023 Reset asserted mid-fetch SHALL take priority over all other inputs and SHALL discard the in-flight response.

Configuration
REQ-024 With macro FETCH_HALT_DECODE_EN defined, a captured word with oper=5'b11111 SHALL be delivered, then force IDLE, discard later responses, and set PC to its address+1; without the macro, such a word SHALL be treated as an ordinary instruction.

Structure
REQ-025 Package cpu_pkg SHALL hold IR width, field bit positions, opcode constants (movsgpr..rnot, HALT=5'b11111), and the fetch state enum.
REQ-026 The 2-entry buffer SHALL be sub-module fetch_fifo (data+pc, push/pop/flush, occupancy out).

Verification
REQ-027 The bench SHALL check: reset, start, ir_ready=1, memory word[i]=i -> ir_pc 0,1,2,... on consecutive cycles, with the first ir_valid 3 cycles after start.
REQ-028 The bench SHALL check: ir_ready=0 for 5 cycles during FETCH -> occupancy 2, no further imem_rd_en, and ir_data held; on release, no gap and no loss.
REQ-029 The bench SHALL check: redirect_pc=20 while word 7 is in flight -> word 7 is never delivered and the next ir_pc is 20.
REQ-030 The bench SHALL check: ADDR_W=5 with PC starting at 30 -> ir_pc sequence 30,31,0,1.
REQ-031 The bench SHALL check: halt at PC=4 with 1 in flight and 1 buffered -> both delivered, busy drops 0, and no further reads.
REQ-032 The bench SHALL check: with FETCH_HALT_DECODE_EN, word 3 = 32'hF800_0000 -> ir_pc 0..3 delivered, state IDLE, PC=4.
